// File: rtl/clock_pkg.sv
// Shared BCD definitions used by the counter and its per-digit step logic.
package clock_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  function automatic logic bcd_digit_valid(input bcd_digit_t digit);
    return digit <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit_step.sv
// One BCD digit of an up/down ripple chain: steps the digit when cin is set
// and reports a carry (9 -> 0 going up) or borrow (0 -> 9 going down).
module bcd_digit_step
  import clock_pkg::*;
(
  input  bcd_digit_t digit,
  input  logic       up,
  input  logic       cin,
  output bcd_digit_t next_digit,
  output logic       cout
);

  // NOTE: every output of an always_comb gets a default first so no path can
  // leave it unassigned, which would otherwise infer a latch.
  always_comb begin
    next_digit = digit;
    cout       = 1'b0;
    if (cin) begin
      if (up) begin
        if (digit >= BCD_MAX) begin
          next_digit = BCD_MIN;
          cout       = 1'b1;
        end else begin
          next_digit = digit + 4'd1;
        end
      end else begin
        if (digit == BCD_MIN) begin
          next_digit = BCD_MAX;
          cout       = 1'b1;
        end else begin
          next_digit = digit - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/bcd_updown_counter.sv
// Modulo-MODULUS BCD up/down counter with validated synchronous load.
// Define BCD_COUNTER_SATURATE_EN to stop at the range limits instead of wrapping.
module bcd_updown_counter
  import clock_pkg::*;
#(
  parameter int DIGITS  = 2,
  parameter int MODULUS = 60
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                up,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] count,
  output logic                wrap,
  output logic                load_err
);

  localparam int W = 4 * DIGITS;

  function automatic logic [W-1:0] to_bcd(input int unsigned value);
    logic [W-1:0] result;
    int unsigned  rest;
    result = '0;
    rest   = value;
    for (int i = 0; i < DIGITS; i++) begin
      result[4*i +: 4] = 4'(rest % 10);
      rest             = rest / 10;
    end
    return result;
  endfunction

  // Valid BCD words order the same way as their decimal values, so the range
  // check is a plain unsigned compare against the top count in BCD form.
  localparam logic [W-1:0] LAST_BCD = to_bcd(MODULUS - 1);

  logic [DIGITS:0] carry;
  logic [W-1:0]    stepped;
  logic            at_limit;
  logic            load_ok;
  logic [W-1:0]    count_d;
  logic            wrap_d;
  logic            load_err_d;

  assign carry[0] = 1'b1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit_step u_step (
      .digit      (count[4*i +: 4]),
      .up         (up),
      .cin        (carry[i]),
      .next_digit (stepped[4*i +: 4]),
      .cout       (carry[i+1])
    );
  end

  // Borrow out of the top digit means every digit was zero.
  assign at_limit = up ? (count == LAST_BCD) : carry[DIGITS];

  always_comb begin
    load_ok = (load_val <= LAST_BCD);
    for (int i = 0; i < DIGITS; i++) begin
      if (!bcd_digit_valid(load_val[4*i +: 4])) load_ok = 1'b0;
    end
  end

  always_comb begin
    count_d    = count;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    if (load) begin
      if (load_ok) count_d = load_val;
      else         load_err_d = 1'b1;
    end else if (en) begin
      if (at_limit) begin
        wrap_d = 1'b1;
`ifdef BCD_COUNTER_SATURATE_EN
        count_d = count;
`else
        count_d = up ? '0 : LAST_BCD;
`endif
      end else begin
        count_d = stepped;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= '0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      count    <= count_d;
      wrap     <= wrap_d;
      load_err <= load_err_d;
    end
  end

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Self-checking bench for bcd_updown_counter (DIGITS=2, MODULUS=60) against an
// integer reference model.
module tb_bcd_updown_counter;

  localparam int DIGITS  = 2;
  localparam int MODULUS = 60;

  logic       clk;
  logic       reset;
  logic       en;
  logic       up;
  logic       load;
  logic [7:0] load_val;
  logic [7:0] count;
  logic       wrap;
  logic       load_err;

  int checks = 0;
  int errors = 0;

  int mval      = 0;
  bit exp_wrap  = 1'b0;
  bit exp_err   = 1'b0;

  bcd_updown_counter #(.DIGITS(DIGITS), .MODULUS(MODULUS)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .wrap     (wrap),
    .load_err (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  // Reference model: count kept as a plain integer in 0..MODULUS-1.
  task automatic model(input logic r, input logic ld, input logic [7:0] lv,
                       input logic e, input logic u);
    int hi;
    int lo;
    exp_wrap = 1'b0;
    exp_err  = 1'b0;
    hi = int'(lv[7:4]);
    lo = int'(lv[3:0]);
    if (r) begin
      mval = 0;
    end else if (ld) begin
      if (hi <= 9 && lo <= 9 && hi * 10 + lo < MODULUS) mval = hi * 10 + lo;
      else exp_err = 1'b1;
    end else if (e) begin
      if (u && mval == MODULUS - 1) begin
        exp_wrap = 1'b1;
`ifndef BCD_COUNTER_SATURATE_EN
        mval = 0;
`endif
      end else if (!u && mval == 0) begin
        exp_wrap = 1'b1;
`ifndef BCD_COUNTER_SATURATE_EN
        mval = MODULUS - 1;
`endif
      end else begin
        mval = u ? mval + 1 : mval - 1;
      end
    end
  endtask

  task automatic cycle(input logic r, input logic ld, input logic [7:0] lv,
                       input logic e, input logic u);
    reset = r; load = ld; load_val = lv; en = e; up = u;
    @(posedge clk);
    #1;
    model(r, ld, lv, e, u);
  endtask

  task automatic test_reset();
    cycle(1'b1, 1'b1, 8'h45, 1'b1, 1'b1);
    checks++;
    if ({count, wrap, load_err} !== {8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: count=%h wrap=%b load_err=%b want count=00 wrap=0 load_err=0",
               count, wrap, load_err);
    end
  endtask

  task automatic test_wrap_up();
    cycle(1'b0, 1'b1, 8'h59, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
      checks++;
      if ({count, wrap, load_err} !== {bcd(mval), exp_wrap, exp_err}) begin
        errors++;
        $display("FAIL wrap_up[%0d]: count=%h wrap=%b load_err=%b want count=%h wrap=%b load_err=%b",
                 i, count, wrap, load_err, bcd(mval), exp_wrap, exp_err);
      end
    end
  endtask

  task automatic test_decrement();
    logic [7:0] starts [2] = '{8'h10, 8'h00};
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 1'b1, starts[i], 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      checks++;
      if ({count, wrap, load_err} !== {bcd(mval), exp_wrap, exp_err}) begin
        errors++;
        $display("FAIL decrement_from_%h: count=%h wrap=%b load_err=%b want count=%h wrap=%b load_err=%b",
                 starts[i], count, wrap, load_err, bcd(mval), exp_wrap, exp_err);
      end
    end
  endtask

  task automatic test_load();
    logic [7:0] vals [5] = '{8'h45, 8'h60, 8'h3A, 8'hA2, 8'h00};
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b1, vals[i], 1'b0, 1'b1);
      checks++;
      if ({count, wrap, load_err} !== {bcd(mval), exp_wrap, exp_err}) begin
        errors++;
        $display("FAIL load_%h: count=%h wrap=%b load_err=%b want count=%h wrap=%b load_err=%b",
                 vals[i], count, wrap, load_err, bcd(mval), exp_wrap, exp_err);
      end
      cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      checks++;
      if ({count, wrap, load_err} !== {bcd(mval), 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL hold_after_load_%h: count=%h wrap=%b load_err=%b want count=%h wrap=0 load_err=0",
                 vals[i], count, wrap, load_err, bcd(mval));
      end
    end
  endtask

  task automatic test_load_priority();
    cycle(1'b0, 1'b1, 8'h20, 1'b1, 1'b1);
    checks++;
    if ({count, wrap, load_err} !== {8'h20, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL load_over_en: count=%h wrap=%b load_err=%b want count=20 wrap=0 load_err=0",
               count, wrap, load_err);
    end
  endtask

  task automatic test_reset_mid();
    cycle(1'b0, 1'b1, 8'h37, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
    checks++;
    if ({count, wrap, load_err} !== {8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_over_en: count=%h wrap=%b load_err=%b want count=00 wrap=0 load_err=0",
               count, wrap, load_err);
    end
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    checks++;
    if ({count, wrap, load_err} !== {8'h01, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL first_step_after_reset: count=%h wrap=%b load_err=%b want count=01 wrap=0 load_err=0",
               count, wrap, load_err);
    end
  endtask

  task automatic test_back_to_back();
    for (int dir = 0; dir < 2; dir++) begin
      for (int i = 0; i < 130; i++) begin
        cycle(1'b0, 1'b0, 8'h00, 1'b1, dir == 0);
        checks++;
        if ({count, wrap, load_err} !== {bcd(mval), exp_wrap, exp_err}) begin
          errors++;
          $display("FAIL sustained_dir%0d[%0d]: count=%h wrap=%b load_err=%b want count=%h wrap=%b load_err=%b",
                   dir, i, count, wrap, load_err, bcd(mval), exp_wrap, exp_err);
        end
      end
    end
  endtask

  task automatic test_random();
    logic       r;
    logic       ld;
    logic [7:0] lv;
    for (int i = 0; i < 600; i++) begin
      r  = ($urandom_range(49) == 0);
      ld = ($urandom_range(5) == 0);
      if ($urandom_range(1) == 0) lv = {4'($urandom_range(6)), 4'($urandom_range(9))};
      else                        lv = 8'($urandom);
      cycle(r, ld, lv, 1'($urandom_range(3) != 0), 1'($urandom));
      checks++;
      if ({count, wrap, load_err} !== {bcd(mval), exp_wrap, exp_err}) begin
        errors++;
        $display("FAIL random[%0d]: count=%h wrap=%b load_err=%b want count=%h wrap=%b load_err=%b",
                 i, count, wrap, load_err, bcd(mval), exp_wrap, exp_err);
      end
    end
  endtask

`ifdef BCD_COUNTER_SATURATE_EN
  task automatic test_saturate();
    cycle(1'b0, 1'b1, 8'h59, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
      checks++;
      if ({count, wrap, load_err} !== {8'h59, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL saturate_top[%0d]: count=%h wrap=%b load_err=%b want count=59 wrap=1 load_err=0",
                 i, count, wrap, load_err);
      end
    end
  endtask
`endif

  initial begin
    reset = 1'b0; load = 1'b0; load_val = 8'h00; en = 1'b0; up = 1'b0;
    test_reset();
    test_wrap_up();
    test_decrement();
    test_load();
    test_load_priority();
    test_reset_mid();
    test_back_to_back();
    test_random();
`ifdef BCD_COUNTER_SATURATE_EN
    test_saturate();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_updown_counter.md
BCD_UPDOWN_COUNTER -- requirements
Module: bcd_updown_counter

Interface
REQ-001 The block SHALL have parameter DIGITS, default 2, giving the number of BCD digits (range 1..6).
REQ-002 The block SHALL have parameter MODULUS, default 60, giving the count range 0..MODULUS-1 (range 2..10**DIGITS).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port en, input, 1 bit: advances the count by one step this cycle.
REQ-006 The block SHALL have port up, input, 1 bit: 1 means increment, 0 means decrement; sampled only with en.
REQ-007 The block SHALL have port load, input, 1 bit: synchronously loads load_val.
REQ-008 The block SHALL have port load_val, input, 4*DIGITS bits: BCD value to load, least significant digit in bits [3:0].
REQ-009 The block SHALL have port count, output, 4*DIGITS bits: registered BCD count.
REQ-010 The block SHALL have port wrap, output, 1 bit: one-cycle pulse when a step crosses the range boundary.
REQ-011 The block SHALL have port load_err, output, 1 bit: one-cycle pulse when a load is rejected.

Function
REQ-012 count SHALL hold a valid BCD value (each nibble 0..9, value < MODULUS) at all times after reset.
REQ-013 Priority SHALL be: reset, then load, then en; when load=1, en is ignored that cycle.
REQ-014 With en=1 and up=1, the count SHALL increment by one decimal unit at the next edge, with digit carries in BCD (for example, 09 becomes 10).
REQ-015 With en=1 and up=0, the count SHALL decrement by one decimal unit at the next edge, with digit borrows in BCD (for example, 10 becomes 09).
REQ-016 An increment from MODULUS-1 SHALL produce 0, and a decrement from 0 SHALL produce MODULUS-1; in either case wrap SHALL be 1 for exactly the cycle in which the new count is visible.
REQ-017 When load_val is valid BCD and less than MODULUS, load SHALL write load_val into count at the next edge, with wrap=0 and load_err=0.
REQ-018 When load_val has any nibble greater than 9, or a value of MODULUS or more, the load SHALL leave count unchanged and pulse load_err for one cycle.
REQ-019 With en=0 and load=0, count SHALL hold, and wrap and load_err SHALL be 0.
REQ-020 Latency from any input change to the count, wrap or load_err update SHALL be exactly one clock; all three outputs are registered, with no combinational input-to-output path.
REQ-021 Sustained en=1 SHALL step once every cycle with no dead cycles, including across wrap.

Reset
REQ-022 While reset=1 at a rising edge, count SHALL become 0 and wrap and load_err SHALL become 0.
REQ-023 Reset SHALL override a simultaneous load or en; the first step after reset is released SHALL start from 0.

Configuration
REQ-024 With the macro BCD_COUNTER_SATURATE_EN defined, the count SHALL stop at MODULUS-1 when incrementing and at 0 when decrementing, with wrap pulsing on each step attempted at the limit.
REQ-025 With BCD_COUNTER_SATURATE_EN undefined, the count SHALL wrap as in REQ-016.

Structure
REQ-026 The shared package clock_pkg SHALL hold the typedef bcd_digit_t (4 bits) and the constants BCD_MAX=9 and BCD_MIN=0.
REQ-027 The design SHALL instantiate DIGITS copies of the sub-module bcd_digit_step, chained least significant first. Each copy is combinational: digit, up and cin in; next digit and cout out, where cout is the carry on 9 to 0 or the borrow on 0 to 9.
REQ-028 The top level SHALL own the registers, the MODULUS compare, load validation and the priority logic.

Verification
REQ-029 With DIGITS=2 and MODULUS=60, count=59, en=1 and up=1 SHALL give count=00 and wrap=1 after one edge, then count=01 and wrap=0.
REQ-030 With count=10, en=1 and up=0 SHALL give count=09; with count=00, en=1 and up=0 SHALL give count=59 with wrap=1.
REQ-031 load=1 with load_val=0x45 SHALL give count=45; load_val=0x60 or 0x3A SHALL leave count unchanged with load_err=1 for one cycle.
REQ-032 load=1 and en=1 in the same cycle with load_val=0x20 SHALL give count=20, with no step applied.
REQ-033 Asserting reset for one cycle while count=37 and en=1 SHALL give count=00 with wrap=0 and load_err=0; en=1 afterwards SHALL give 01.
REQ-034 With BCD_COUNTER_SATURATE_EN defined, count=59 with en=1 and up=1 for three cycles SHALL hold count at 59 with wrap=1 on each cycle.
